// File: rtl/sdram_pkg.sv
// Shared SDRAM port types: master IDs, word-address width and the command payload.
package sdram_pkg;

  localparam int unsigned ADDR_W    = 29;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned BE_W      = DATA_W / 8;
  localparam int unsigned BURST_W   = 8;
  localparam int unsigned PENDING_W = 7;

  typedef enum logic {
    MASTER_DISPLAY = 1'b0,
    MASTER_RAST    = 1'b1
  } master_e;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
  } sdram_cmd_t;

endpackage

// File: rtl/sdram_tag_fifo.sv
// Register-based FIFO of master IDs, one entry per outstanding SDRAM read.
module sdram_tag_fifo
  import sdram_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  master_e                push_tag,
  input  logic                   pop,
  output master_e                pop_tag,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  master_e            mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  // Pops on an empty FIFO are dropped; pointers wrap naturally at the power-of-2 depth.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign pop_tag = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= MASTER_DISPLAY;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_tag;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
      else if (!push_ok && pop_ok) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-master SDRAM arbiter: display over rasterizer, grant locked while stalled, read tags routed back.
// Optional SDRAM_ARBITER_FAIRNESS_EN forces one rasterizer command after FAIR_LIMIT display grants.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned MAX_PENDING = 16,
  parameter int unsigned FAIR_LIMIT  = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [ADDR_W-1:0]    d_address,
  input  logic                 d_read,
  output logic                 d_waitrequest,
  output logic                 d_readdatavalid,
  input  logic [ADDR_W-1:0]    r_address,
  input  logic                 r_read,
  input  logic                 r_write,
  input  logic [DATA_W-1:0]    r_writedata,
  input  logic [BE_W-1:0]      r_byteenable,
  output logic                 r_waitrequest,
  output logic                 r_readdatavalid,
  output logic [ADDR_W-1:0]    s_address,
  output logic                 s_read,
  output logic                 s_write,
  output logic [DATA_W-1:0]    s_writedata,
  output logic [BE_W-1:0]      s_byteenable,
  output logic [BURST_W-1:0]   s_burstcount,
  input  logic                 s_waitrequest,
  input  logic                 s_readdatavalid,
  output logic [PENDING_W-1:0] pending
);

  localparam int unsigned CNT_W = $clog2(MAX_PENDING) + 1;

  if (MAX_PENDING < 2 || MAX_PENDING > 64 || (MAX_PENDING & (MAX_PENDING - 1)) != 0
      || FAIR_LIMIT < 1) begin : g_bad_cfg
    $error("sdram_arbiter: unsupported MAX_PENDING or FAIR_LIMIT");
  end

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  lock_state_e      state, state_next;
  master_e          lock_master, lock_master_next;
  master_e          grant;
  master_e          pop_tag;
  sdram_cmd_t       cmd;
  logic             cmd_valid;
  logic             accept;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic             d_eligible;
  logic             r_eligible;
  logic             force_rast;

  // A read that would overflow the tag FIFO is simply not eligible, so it never takes the lock.
  assign d_eligible = d_read && !fifo_full;
  assign r_eligible = r_write || (r_read && !fifo_full);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_OPEN;
      lock_master <= MASTER_DISPLAY;
    end else begin
      state       <= state_next;
      lock_master <= lock_master_next;
    end
  end

  always_comb begin
    state_next       = ST_OPEN;
    lock_master_next = lock_master;
    grant            = MASTER_DISPLAY;
    cmd              = '0;
    if (state == ST_LOCKED)             grant = lock_master;
    else if (force_rast && r_eligible)  grant = MASTER_RAST;
    else if (!d_eligible && r_eligible) grant = MASTER_RAST;
    cmd_valid = reset_n && ((grant == MASTER_DISPLAY) ? d_eligible : r_eligible);
    if (cmd_valid) begin
      if (grant == MASTER_DISPLAY) begin
        cmd.address = d_address;
        cmd.read    = 1'b1;
      end else begin
        cmd.address    = r_address;
        cmd.read       = r_read;
        cmd.write      = r_write;
        cmd.writedata  = r_writedata;
        cmd.byteenable = r_byteenable;
      end
      if (s_waitrequest) begin
        state_next       = ST_LOCKED;
        lock_master_next = grant;
      end
    end
  end

  assign accept        = cmd_valid && !s_waitrequest;
  assign s_address     = cmd.address;
  assign s_read        = cmd.read;
  assign s_write       = cmd.write;
  assign s_writedata   = cmd.writedata;
  assign s_byteenable  = cmd.byteenable;
  assign s_burstcount  = BURST_W'(1);
  assign d_waitrequest = !(cmd_valid && grant == MASTER_DISPLAY) || s_waitrequest;
  assign r_waitrequest = !(cmd_valid && grant == MASTER_RAST) || s_waitrequest;

  sdram_tag_fifo #(.DEPTH(MAX_PENDING)) u_tag_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (accept && cmd.read),
    .push_tag (grant),
    .pop      (s_readdatavalid),
    .pop_tag  (pop_tag),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Responses with no outstanding tag are protocol errors and produce no strobe.
  assign d_readdatavalid = s_readdatavalid && !fifo_empty && (pop_tag == MASTER_DISPLAY);
  assign r_readdatavalid = s_readdatavalid && !fifo_empty && (pop_tag == MASTER_RAST);
  assign pending         = PENDING_W'(fifo_count);

`ifdef SDRAM_ARBITER_FAIRNESS_EN
  localparam int unsigned FAIR_W = $clog2(FAIR_LIMIT + 1);
  logic [FAIR_W-1:0] fair_count;

  // Counts display acceptances that overtook a waiting rasterizer request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fair_count <= '0;
    end else if (accept) begin
      if (grant == MASTER_RAST)            fair_count <= '0;
      else if (!(r_read || r_write))       fair_count <= '0;
      else if (fair_count < FAIR_W'(FAIR_LIMIT)) fair_count <= fair_count + FAIR_W'(1);
    end
  end

  assign force_rast = (fair_count >= FAIR_W'(FAIR_LIMIT));
`else
  assign force_rast = 1'b0;
`endif

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter MAX_PENDING, default 16: maximum outstanding accepted reads (power of 2, 2..64).
REQ-002 SHALL have parameter FAIR_LIMIT, default 8: consecutive display grants before the rasterizer is forced through.
REQ-003 SHALL have port clock  input  1  single clock domain, all logic posedge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port d_address  input  29  display (frame buffer) read address, 64-bit word units.
REQ-006 SHALL have port d_read  input  1  display read request.
REQ-007 SHALL have port d_waitrequest  output  1  display stall.
REQ-008 SHALL have port d_readdatavalid  output  1  returning word belongs to the display.
REQ-009 SHALL have port r_address  input  29  rasterizer address, 64-bit word units.
REQ-010 SHALL have port r_read / r_write  input  1 each  rasterizer requests, mutually exclusive.
REQ-011 SHALL have port r_writedata  input  64  and port r_byteenable  input  8: rasterizer write payload.
REQ-012 SHALL have port r_waitrequest  output  1  and port r_readdatavalid  output  1: rasterizer stall and return strobe.
REQ-013 SHALL have ports s_address  output  29, s_read, s_write  output  1, s_writedata  output  64, s_byteenable  output  8, s_burstcount  output  8, constant 1.
REQ-014 SHALL have ports s_waitrequest, s_readdatavalid  input  1: SDRAM controller handshake; s_readdata is wired directly to both masters and is not routed through this block.
REQ-015 SHALL have port pending  output  7  count of outstanding reads.

Function
REQ-016 SHALL drive the s_* command signals combinationally from the granted master; an ungranted master sees waitrequest=1.
REQ-017 SHALL grant by fixed priority, display over rasterizer, evaluated each cycle in which no command is locked.
REQ-018 SHALL lock the grant while the presented command has s_waitrequest=1; grant re-evaluates only in the cycle after acceptance (s_read|s_write and !s_waitrequest).
REQ-019 SHALL block any read, from either master, while pending==MAX_PENDING; writes are not blocked; the blocked read does not hold the lock.
REQ-020 SHALL push the master ID (0=display, 1=rasterizer) into a tag FIFO on every accepted read.
REQ-021 SHALL pop the tag FIFO on s_readdatavalid and assert exactly one of d_/r_readdatavalid in the same cycle, combinationally.
REQ-022 SHALL handle a simultaneous push and pop: pending unchanged, order preserved.
REQ-023 SHALL ignore s_readdatavalid while the tag FIFO is empty (no strobe out, pending stays 0; protocol error).
REQ-024 SHALL wrap tag FIFO pointers modulo MAX_PENDING; pending SHALL never exceed MAX_PENDING.
REQ-025 SHALL apply back-to-back acceptance with zero added latency: master waitrequest = s_waitrequest when granted and not blocked.

Reset
REQ-026 SHALL, on reset_n low, asynchronously clear the tag FIFO, pending, lock and fairness counter; all s_* command outputs SHALL be 0 and d_/r_waitrequest SHALL be 1 during reset.
REQ-027 SHALL discard outstanding tags on reset mid-operation; responses arriving afterwards fall under REQ-023.

Configuration
REQ-028 SHALL, with SDRAM_ARBITER_FAIRNESS_EN defined, count consecutive display acceptances while r_read|r_write is pending and, at FAIR_LIMIT, grant the rasterizer for one accepted command, then reset the count; without the macro, priority SHALL be strictly fixed and the counter SHALL be absent.

Structure
REQ-029 SHALL take the master ID enum (MASTER_DISPLAY, MASTER_RAST) and the SDRAM word address width (29) from a shared package, sdram_pkg.
REQ-030 SHALL implement the tag FIFO as one sub-module, sdram_tag_fifo (width 1, depth MAX_PENDING, registers, not RAM).

Verification
REQ-031 SHALL cover: both masters request reads at 0x100/0x200 with s_waitrequest=0 -> display accepted first, rasterizer next cycle, returns routed D then R.
REQ-032 SHALL cover: s_waitrequest held high 5 cycles while the display is granted, then the rasterizer asserts -> s_address remains the display address until acceptance.
REQ-033 SHALL cover: 16 display reads with no returns -> pending=16, a 17th read stalled, an r_write of 0xDEADBEEF accepted; one return -> read proceeds.
REQ-034 SHALL cover: accept and return in the same cycle at pending=3 -> pending stays 3, correct master strobed.
REQ-035 SHALL cover: FAIRNESS_EN with continuous d_read and r_write -> one rasterizer write every 9th acceptance; macro off -> rasterizer starves.
REQ-036 SHALL cover: reset asserted with pending=5 -> pending=0; subsequent s_readdatavalid produces no strobes.
